// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, transmitter and byte FIFOs.
// Depth helpers are kept here so every FIFO sizes its pointers the same way.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-push and FWFT read-port bundle between UART receiver, RX FIFO and consumer.
// The slave side is the FIFO; the master side drives pushes and pops.
interface uart_rx_fifo_if #(
  parameter int DEPTH = uart_pkg::UART_FIFO_DEPTH
);
  import uart_pkg::*;

  localparam int AW = fifo_aw(DEPTH);

  uart_byte_t din;
  logic       rx_done_tick;
  uart_byte_t rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [AW:0] count;
  logic       full;
  logic       overflow;
  logic       clr_overflow;

  modport slave (
    input  din,
    input  rx_done_tick,
    input  rd_ready,
    input  clr_overflow,
    output rd_data,
    output rd_valid,
    output count,
    output full,
    output overflow
  );

  modport master (
    output din,
    output rx_done_tick,
    output rd_ready,
    output clr_overflow,
    input  rd_data,
    input  rd_valid,
    input  count,
    input  full,
    input  overflow
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte buffer behind the UART receiver with a first-word-fall-through
// read port; full/empty come from the occupancy count, not pointer equality.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  uart_rx_fifo_if.slave bus
);

  localparam int ADDR_W = fifo_aw(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  uart_byte_t        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic rd_valid;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == CNT_FULL);
  assign pop      = rd_valid & bus.rd_ready;
  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign push     = bus.rx_done_tick & (~full | pop);
  assign drop     = bus.rx_done_tick & ~push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (bus.clr_overflow) ovf_d = 1'b0;
    if (drop)             ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= bus.din;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign bus.rd_valid = rd_valid;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.overflow = ovf_q;

`ifndef SYNTHESIS
  logic [ADDR_W-1:0] ptr_diff;
  assign ptr_diff = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CNT_FULL)
        else $error("count %0d above depth", count_q);
      if (count_q != CNT_FULL)
        assert (count_q[ADDR_W-1:0] == ptr_diff && !count_q[ADDR_W])
          else $error("count %0d vs ptr diff %0d", count_q, ptr_diff);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: fill, drain, overflow, wrap and reset cases.
// Inputs change and outputs are checked 1 ns after each rising edge.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.din = b;
    bus.rx_done_tick = 1'b1;
    tick();
    bus.rx_done_tick = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.din = '0;
    bus.rx_done_tick = 1'b0;
    bus.rd_ready = 1'b0;
    bus.clr_overflow = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_valid", 32'(bus.rd_valid), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);

    // Three bytes, then read them back in order
    push(8'h41);
    push(8'h42);
    push(8'h43);
    chk("abc_count", 32'(bus.count), 3);
    chk("abc_valid", 32'(bus.rd_valid), 1);
    chk("abc_head", 32'(bus.rd_data), 32'h41);
    bus.rd_ready = 1'b1;
    tick();
    chk("abc_rd1", 32'(bus.rd_data), 32'h42);
    tick();
    chk("abc_rd2", 32'(bus.rd_data), 32'h43);
    tick();
    bus.rd_ready = 1'b0;
    chk("abc_empty", 32'(bus.rd_valid), 0);
    chk("abc_cnt0", 32'(bus.count), 0);

    // Fill, drop one byte, drain
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 16);
    chk("fill_ovf0", 32'(bus.overflow), 0);
    push(8'hAA);
    chk("drop_ovf", 32'(bus.overflow), 1);
    chk("drop_count", 32'(bus.count), 16);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", 32'(bus.rd_data), 32'(i));
      tick();
    end
    bus.rd_ready = 1'b0;
    chk("drain_empty", 32'(bus.rd_valid), 0);
    chk("drain_ovf", 32'(bus.overflow), 1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 0);

    // Simultaneous push and pop on a full queue
    for (int i = 0; i < DEPTH; i++) push(8'(8'h60 + i));
    bus.din = 8'h55;
    bus.rx_done_tick = 1'b1;
    bus.rd_ready = 1'b1;
    tick();
    bus.rx_done_tick = 1'b0;
    bus.rd_ready = 1'b0;
    chk("fpp_count", 32'(bus.count), 16);
    chk("fpp_ovf", 32'(bus.overflow), 0);
    chk("fpp_head", 32'(bus.rd_data), 32'h61);
    bus.rd_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      chk("fpp_data", 32'(bus.rd_data), 32'(8'h60 + i));
      tick();
    end
    chk("fpp_last", 32'(bus.rd_data), 32'h55);
    tick();
    bus.rd_ready = 1'b0;
    chk("fpp_empty", 32'(bus.count), 0);

    // Streaming 40 bytes one-deep across pointer wrap
    push(8'h10);
    bus.rd_ready = 1'b1;
    bus.rx_done_tick = 1'b1;
    for (int k = 1; k < 40; k++) begin
      chk("strm_data", 32'(bus.rd_data), 32'(8'h10 + k - 1));
      chk("strm_count", 32'(bus.count), 1);
      bus.din = 8'(8'h10 + k);
      tick();
    end
    bus.rx_done_tick = 1'b0;
    chk("strm_tail", 32'(bus.rd_data), 32'h37);
    tick();
    bus.rd_ready = 1'b0;
    chk("strm_empty", 32'(bus.count), 0);

    // Drop colliding with clear: set wins
    for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
    push(8'hEE);
    chk("ovf_set", 32'(bus.overflow), 1);
    bus.din = 8'hEF;
    bus.rx_done_tick = 1'b1;
    bus.clr_overflow = 1'b1;
    tick();
    bus.rx_done_tick = 1'b0;
    chk("ovf_setwins", 32'(bus.overflow), 1);
    tick();
    bus.clr_overflow = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 0);
    chk("ovf_count", 32'(bus.count), 16);
    chk("ovf_head", 32'(bus.rd_data), 32'h80);

    // Reset mid-operation with push and pop requested
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    chk("mid_count5", 32'(bus.count), 5);
    push(8'hDD);
    push(8'hDE);
    bus.din = 8'hDF;
    bus.rx_done_tick = 1'b1;
    bus.rd_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rd_ready = 1'b0;
    chk("mid_count", 32'(bus.count), 0);
    chk("mid_valid", 32'(bus.rd_valid), 0);
    chk("mid_ovf", 32'(bus.overflow), 0);
    chk("mid_full", 32'(bus.full), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
